// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle add/sub/shift/logic ops and a
// WIDTH-cycle shift-add multiply, with registered result and Z/N/C/V flags.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             cout,
    output logic             v,
    output logic             z,
    output logic             n
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SHL = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    localparam logic [WIDTH-1:0] WIDTH_V   = WIDTH'(WIDTH);
    localparam logic [SHW-1:0]   LAST_STEP = SHW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]     d_q, d_d;
    logic                 cout_q, cout_d;
    logic                 v_q, v_d;
    logic                 z_q, z_d;
    logic                 n_q, n_d;
    logic                 live_q;

    logic [WIDTH-1:0]     b_x;
    logic [WIDTH:0]       sum;
    logic [SHW-1:0]       shamt;
    logic                 shift_big;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   acc_step;

    // Single-cycle datapath, evaluated directly on the input operands.
    always_comb begin
        b_x       = (op == OP_SUB) ? ~b : b;
        sum       = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, (op == OP_SUB)};
        shamt     = b[SHW-1:0];
        shift_big = (b >= WIDTH_V);
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL:  alu_res = shift_big ? '0 : (a << shamt);
            OP_SHR:  alu_res = shift_big ? '0 : (a >> shamt);
            OP_SRA:  alu_res = shift_big ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> shamt);
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            default: alu_res = '0;
        endcase
    end

    // One multiply step: conditionally add the multiplicand into the upper
    // half, then shift the whole accumulator right (multiplier drains from the low half).
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
        acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        cout_d  = cout_q;
        v_d     = v_q;
        z_d     = z_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                if (live_q && in_valid) begin
                    if (op == OP_MUL) begin
                        a_d     = a;
                        acc_d   = {{WIDTH{1'b0}}, b};
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        d_d     = alu_res;
                        cout_d  = alu_c;
                        v_d     = alu_v;
                        z_d     = (alu_res == '0);
                        n_d     = alu_res[WIDTH-1];
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    d_d     = acc_step[WIDTH-1:0];
                    cout_d  = 1'b0;
                    v_d     = |acc_step[2*WIDTH-1:WIDTH];
                    z_d     = (acc_step[WIDTH-1:0] == '0);
                    n_d     = acc_step[WIDTH-1];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            d_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
            z_q     <= z_d;
            n_q     <= n_d;
            live_q  <= 1'b1;
        end
    end

    // Hold off acceptance until the first clock edge after reset release.
    assign in_ready  = live_q && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = d_q;
    assign cout      = cout_q;
    assign v         = v_q;
    assign z         = z_q;
    assign n         = n_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked sequential ALU. It is the successor to the fixed 32-bit combinational ALU used in the datapath.

- Width is set by `WIDTH`; the opcode set grows to the full 3-bit space.
- Adds subtract, logical/arithmetic right shift, OR, and an iterative multi-cycle multiply.
- Results are registered with Z/N/C/V flags.
- Operands arrive on a valid/ready input channel; results leave on a valid/ready output channel with full backpressure.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width in bits (≥ 4).
- `SHW`, `$clog2(WIDTH)`: derived; width of the shift-amount field used internally.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands and op are valid this cycle.
- `in_ready`  out  1  block can accept an operation.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B (also the shift amount).
- `op`  in  3  operation select.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer accepts the result.
- `d`  out  WIDTH  result.
- `cout`  out  1  carry / no-borrow flag.
- `v`  out  1  overflow flag.
- `z`  out  1  result is zero.
- `n`  out  1  result MSB.

## Operation
- Opcode map:
  - 000 ADD: d=a+b.
  - 001 SHL: d=a<<b.
  - 010 SUB: d=a-b.
  - 011 SHR: logical right shift.
  - 100 SRA: arithmetic right shift.
  - 101 OR.
  - 110 MUL: low WIDTH bits of unsigned a*b.
  - 111 AND.
- FSM states:
  - IDLE: `in_ready`=1. `in_valid`=1 latches a, b, op. Single-cycle ops compute and go to DONE. MUL goes to BUSY.
  - BUSY: one shift-add step per cycle, exactly WIDTH steps, using a 2·WIDTH-bit accumulator. After the last step, go to DONE.
  - DONE: `out_valid`=1. `d` and the flags are held stable. `out_ready`=1 returns to IDLE.
- `in_ready` is 1 only in IDLE. Inputs are ignored in BUSY and DONE; `a`/`b`/`op` may change freely there.
- ADD/SUB:
  - SUB is a+~b+1 at WIDTH+1 bits.
  - `cout` is bit WIDTH of that sum. For SUB, `cout`=1 means no borrow (a ≥ b unsigned).
  - `v` is signed overflow: operand signs agree (ADD) or differ (SUB), and the result sign differs from a.
- Shifts: if b ≥ WIDTH, SHL/SHR give 0 and SRA gives all copies of a[WIDTH-1]. `cout`=`v`=0.
- MUL: `v`=1 iff the upper WIDTH bits of the full product are nonzero. `cout`=0.
- Logic ops: `cout`=`v`=0.
- `z` = (d==0) and `n` = d[WIDTH-1] for every op. Flags are registered with `d`.

## Timing
- Reset values: state IDLE, `out_valid`=0, `d`=0, `cout`=`v`=0, `z`=0, `n`=0, accumulator 0. `in_ready`=1 from the first edge after `rst_n` deasserts.
- Single-cycle ops: accepted at edge T; `out_valid`=1 from T+1.
- MUL: accepted at edge T; `out_valid`=1 from T+WIDTH+1.
- Result transfer occurs on an edge with `out_valid`&&`out_ready`. `in_ready` rises the following cycle.
- Throughput: one single-cycle op per 2 cycles, with no overlap between the output and input handshakes.
- Backpressure: `out_ready`=0 holds DONE indefinitely, with `d`/flags unchanged.
- Reset mid-operation (BUSY or DONE) aborts immediately. Outputs go to reset values asynchronously and no result is emitted.
- `out_ready` asserted outside DONE has no effect.

## Test plan
- ADD, WIDTH=32, a=0x7FFFFFFF, b=1, `out_ready`=1:
  - d=0x80000000, v=1, cout=0, n=1, z=0.
  - `out_valid` one cycle after acceptance.
- SUB:
  - a=5, b=7 → d=0xFFFFFFFE, cout=0, v=0, n=1.
  - a=7, b=7 → d=0, z=1, cout=1.
- Shift bounds:
  - SHL a=1, b=31 → 0x80000000.
  - SHL b=32 → 0.
  - SRA a=0x80000000, b=40 → 0xFFFFFFFF.
  - SHR same operands → 0.
- MUL:
  - a=0x10000, b=0x10000 → d=0, v=1, z=1.
  - a=3, b=5 → d=15, v=0.
  - `out_valid` exactly 33 cycles after acceptance.
  - `in_ready`=0 throughout.
- Backpressure: MUL result with `out_ready` held 0 for 10 cycles.
  - d/flags are stable and `in_ready`=0 throughout.
  - A new `in_valid` during the stall is ignored.
  - Asserting `out_ready` gives one transfer, then IDLE.
- Reset: assert `rst_n`=0 on BUSY cycle 10 of a MUL.
  - `out_valid`=0 and d=0 immediately.
  - After release, an ADD 2+3 returns d=5 with no stale MUL result.
